// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment countdown displays.
// Holds the segment codes, the digit-slot indices and the value-to-digit arithmetic.
package seg_pkg;

  typedef logic [1:0] dig_idx_t;

  localparam dig_idx_t DIG_A_TENS = 2'd0;
  localparam dig_idx_t DIG_A_ONES = 2'd1;
  localparam dig_idx_t DIG_B_TENS = 2'd2;
  localparam dig_idx_t DIG_B_ONES = 2'd3;

  // Segment order is {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  // Returns {tens, ones}; a compare/subtract chain keeps a divider out of the netlist.
  function automatic logic [7:0] split_bcd(input logic [6:0] v);
    logic [6:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    for (int k = 9; k >= 1; k--) begin
      if (t == 4'd0 && r >= 7'(10 * k)) begin
        t = 4'(k);
        r = r - 7'(10 * k);
      end
    end
    return {t, r[3:0]};
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational decimal digit to 7-segment pattern; codes 10..15 render dark.
module seg7_encode
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Scans two 2-digit countdown displays over one shared segment bus, with
// inter-digit blanking, leading-zero suppression and tick-synchronised flashing.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] val_a,
  input  logic [6:0] val_b,
  input  logic       blank_lz,
  input  logic       flash_a,
  input  logic       flash_b,
  input  logic       tick_1hz,
  output logic [6:0] seg,
  output logic [3:0] dig_en,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] slot_cnt;
  dig_idx_t         dig_idx;
  logic [6:0]       snap_a;
  logic [6:0]       snap_b;
  logic             flash_a_q;
  logic             flash_b_q;
  logic             blink_ph;

  logic             slot_first;
  logic             slot_last;
  logic [7:0]       bcd_a;
  logic [7:0]       bcd_b;
  logic [3:0]       digit;
  logic             is_tens;
  logic             disp_dark;
  logic             show;
  logic [6:0]       enc_seg;
  logic [6:0]       seg_nxt;
  logic [3:0]       dig_en_nxt;

  assign slot_first = (slot_cnt == '0);
  assign slot_last  = (slot_cnt == CNT_W'(SCAN_DIV - 1));

  seg7_encode u_encode (
    .digit (digit),
    .seg   (enc_seg)
  );

  always_comb begin
    bcd_a     = split_bcd(snap_a);
    bcd_b     = split_bcd(snap_b);
    digit     = 4'd0;
    is_tens   = 1'b0;
    disp_dark = 1'b0;
    case (dig_idx)
      DIG_A_TENS: begin
        digit     = bcd_a[7:4];
        is_tens   = 1'b1;
        disp_dark = flash_a_q & blink_ph;
      end
      DIG_A_ONES: begin
        digit     = bcd_a[3:0];
        disp_dark = flash_a_q & blink_ph;
      end
      DIG_B_TENS: begin
        digit     = bcd_b[7:4];
        is_tens   = 1'b1;
        disp_dark = flash_b_q & blink_ph;
      end
      default: begin
        digit     = bcd_b[3:0];
        disp_dark = flash_b_q & blink_ph;
      end
    endcase

    // A zero tens digit under blank_lz behaves exactly like the anti-ghost window.
    show = (slot_cnt >= CNT_W'(BLANK_CYC))
         && !(is_tens && blank_lz && digit == 4'd0)
         && !disp_dark;

    seg_nxt    = show ? enc_seg : SEG_OFF;
    dig_en_nxt = show ? (4'b0001 << dig_idx) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt   <= '0;
      dig_idx    <= DIG_A_TENS;
      snap_a     <= '0;
      snap_b     <= '0;
      flash_a_q  <= 1'b0;
      flash_b_q  <= 1'b0;
      blink_ph   <= 1'b0;
      seg        <= SEG_OFF;
      dig_en     <= 4'b0000;
      frame_done <= 1'b0;
    end else begin
      slot_cnt <= slot_last ? '0 : slot_cnt + CNT_W'(1);
      if (slot_last) begin
        dig_idx <= dig_idx + 2'd1;
      end
      // Values are frozen for a whole frame so both digits of a display agree.
      if (slot_first && dig_idx == DIG_A_TENS) begin
        snap_a <= sat99(val_a);
        snap_b <= sat99(val_b);
      end
      if (slot_first) begin
        flash_a_q <= flash_a;
        flash_b_q <= flash_b;
      end
      if (tick_1hz) begin
        blink_ph <= ~blink_ph;
      end
      seg        <= seg_nxt;
      dig_en     <= dig_en_nxt;
      frame_done <= slot_last && (dig_idx == DIG_B_ONES);
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver at SCAN_DIV=8, BLANK_CYC=2 (32-cycle frame).
module tb_seg_scan_driver;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = SD * 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] val_a = '0;
  logic [6:0] val_b = '0;
  logic       blank_lz = 1'b0;
  logic       flash_a = 1'b0;
  logic       flash_b = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [6:0] seg;
  logic [3:0] dig_en;
  logic       frame_done;

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .reset      (reset),
    .val_a      (val_a),
    .val_b      (val_b),
    .blank_lz   (blank_lz),
    .flash_a    (flash_a),
    .flash_b    (flash_b),
    .tick_1hz   (tick_1hz),
    .seg        (seg),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: edges counted since reset release, digits by plain arithmetic.
  logic [6:0] codes [10];
  int  m_n = 0;
  int  m_snap_a = 0, m_snap_b = 0;
  bit  m_fa = 0, m_fb = 0, m_ph = 0;

  task automatic step();
    logic [6:0] e_seg;
    logic [3:0] e_en;
    logic       e_fd;
    int sc, di, v, tens, ones, d;
    bit show, fl;
    e_seg = '0; e_en = '0; e_fd = 1'b0;
    if (reset) begin
      m_n = 0; m_snap_a = 0; m_snap_b = 0; m_fa = 0; m_fb = 0; m_ph = 0;
    end else begin
      sc = m_n % SD;
      di = (m_n / SD) % 4;
      v = (di >= 2) ? m_snap_b : m_snap_a;
      fl = (di >= 2) ? m_fb : m_fa;
      tens = v / 10;
      ones = v % 10;
      d = (di % 2 == 1) ? ones : tens;
      show = (sc >= BC) && !(di % 2 == 0 && blank_lz && tens == 0) && !(fl && m_ph);
      if (show) begin
        e_seg = codes[d];
        e_en = 4'(1 << di);
      end
      e_fd = (m_n % FRAME == FRAME - 1);
      if (sc == 0 && di == 0) begin
        m_snap_a = (val_a > 99) ? 99 : int'(val_a);
        m_snap_b = (val_b > 99) ? 99 : int'(val_b);
      end
      if (sc == 0) begin
        m_fa = flash_a;
        m_fb = flash_b;
      end
      if (tick_1hz) m_ph = ~m_ph;
      m_n++;
    end
    @(posedge clk);
    #1;
    check("cycle_outputs", {21'd0, frame_done, dig_en, seg}, {21'd0, e_fd, e_en, e_seg});
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    check("reset_seg", 32'(seg), 32'h0);
    check("reset_dig_en", 32'(dig_en), 32'h0);
    check("reset_frame_done", 32'(frame_done), 32'h0);
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [6:0] val;
    logic       lz;
    logic [6:0] tens_seg;
    logic [3:0] tens_en;
    logic [6:0] ones_seg;
  } vec_t;

  vec_t vecs [10];
  logic [6:0] cap_seg [64];
  logic [3:0] cap_en  [64];
  logic       cap_fd  [100];

  initial begin
    codes = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    vecs[0] = '{7'd9,   1'b0, 7'h3F, 4'b0001, 7'h6F};
    vecs[1] = '{7'd9,   1'b1, 7'h00, 4'b0000, 7'h6F};
    vecs[2] = '{7'd0,   1'b1, 7'h00, 4'b0000, 7'h3F};
    vecs[3] = '{7'd0,   1'b0, 7'h3F, 4'b0001, 7'h3F};
    vecs[4] = '{7'd23,  1'b1, 7'h5B, 4'b0001, 7'h4F};
    vecs[5] = '{7'd99,  1'b0, 7'h6F, 4'b0001, 7'h6F};
    vecs[6] = '{7'd120, 1'b0, 7'h6F, 4'b0001, 7'h6F};
    vecs[7] = '{7'd50,  1'b1, 7'h6D, 4'b0001, 7'h3F};
    vecs[8] = '{7'd81,  1'b0, 7'h7F, 4'b0001, 7'h06};
    vecs[9] = '{7'd47,  1'b0, 7'h66, 4'b0001, 7'h07};

    // Display A digit split, encoding, saturation and leading-zero blank.
    for (int t = 0; t < 10; t++) begin
      do_reset();
      val_a = vecs[t].val;
      val_b = 7'd7;
      blank_lz = vecs[t].lz;
      for (int c = 0; c < 16; c++) begin
        step();
        if (c == 5) begin
          check("vec_tens_seg", 32'(seg), 32'(vecs[t].tens_seg));
          check("vec_tens_en", 32'(dig_en), 32'(vecs[t].tens_en));
        end
        if (c == 13) begin
          check("vec_ones_seg", 32'(seg), 32'(vecs[t].ones_seg));
          check("vec_ones_en", 32'(dig_en), 32'h2);
        end
      end
    end

    // Mid-frame value change and saturation on display B.
    blank_lz = 1'b0;
    val_a = 7'd23;
    val_b = 7'd120;
    do_reset();
    for (int c = 0; c < 64; c++) begin
      if (c == 16) val_a = 7'd35;
      step();
      cap_seg[c] = seg;
      cap_en[c] = dig_en;
    end
    check("midchg_f1_tens", 32'(cap_seg[5]), 32'h5B);
    check("midchg_f1_ones", 32'(cap_seg[13]), 32'h4F);
    check("sat_b_tens", 32'(cap_seg[21]), 32'h6F);
    check("sat_b_ones", 32'(cap_seg[29]), 32'h6F);
    check("midchg_f2_tens", 32'(cap_seg[37]), 32'h4F);
    check("midchg_f2_ones", 32'(cap_seg[45]), 32'h6D);
    check("b_ones_en", 32'(cap_en[29]), 32'h8);

    // Flashing: one tick darkens A, B stays lit; second tick restores A.
    val_a = 7'd42;
    val_b = 7'd17;
    flash_a = 1'b1;
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    for (int c = 0; c < 32; c++) begin
      step();
      cap_seg[c] = seg;
      cap_en[c] = dig_en;
    end
    check("flash_a_dark", 32'(cap_en[5]), 32'h0);
    check("flash_b_lit", 32'(cap_en[21]), 32'h4);
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    run(FRAME);
    flash_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
      run(20);
    end

    // Reset mid-slot, then fresh snapshot on release.
    val_a = 7'd58;
    do_reset();
    run(19);
    reset = 1'b1;
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    check("midrst_seg", 32'(seg), 32'h0);
    check("midrst_en", 32'(dig_en), 32'h0);
    check("midrst_fd", 32'(frame_done), 32'h0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      cap_seg[c] = seg;
      cap_en[c] = dig_en;
    end
    check("rel_blank0", 32'(cap_en[0]), 32'h0);
    check("rel_blank1", 32'(cap_en[1]), 32'h0);
    check("rel_first_en", 32'(cap_en[2]), 32'h1);
    check("rel_first_seg", 32'(cap_seg[2]), 32'h6D);

    // frame_done cadence.
    do_reset();
    for (int c = 0; c < 100; c++) begin
      step();
      cap_fd[c] = frame_done;
    end
    begin
      int pulses, first, dbl;
      pulses = 0; first = -1; dbl = 0;
      for (int c = 0; c < 100; c++) begin
        if (cap_fd[c]) begin
          pulses++;
          if (first < 0) first = c;
          if (c > 0 && cap_fd[c-1]) dbl++;
        end
      end
      check("fd_first_edge", 32'(first + 1), 32'(FRAME));
      check("fd_pulse_count", 32'(pulses), 32'd3);
      check("fd_no_double", 32'(dbl), 32'd0);
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 20) == 0) val_a = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 20) == 0) val_b = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 60) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 50) == 0) flash_a = ~flash_a;
      if ($urandom_range(0, 50) == 0) flash_b = ~flash_b;
      tick_1hz = ($urandom_range(0, 30) == 0);
      reset = ($urandom_range(0, 500) == 0);
      step();
    end
    reset = 1'b0;
    tick_1hz = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
